stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N-channel, W-bit registered stream multiplexer. It is the successor to the 16-bit 8:1 combinational datapath mux. Each input channel carries a valid/ready handshake. The block selects one channel per cycle, either by an explicit `sel` index or by round-robin arbitration, and registers the chosen word into a single output stage with its own valid/ready handshake. It sits between multiple producers (register-file read ports, memory return, I/O) and one shared consumer in the processor datapath.

## Interface
Parameters:
- `WIDTH`, 16: data width per channel.
- `CHANNELS`, 8: number of input channels. Legal range is 2..16.
- `SEL_W`, 3: width of `sel` and `out_chan`. Must satisfy 2^SEL_W >= CHANNELS.

Ports:
- `clk`, input, 1: the single clock. All state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `in_data`, input, CHANNELS*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`, input, CHANNELS: per-channel word available.
- `in_ready`, output, CHANNELS: per-channel accept. At most one bit is high in any cycle.
- `mode`, input, 1: 0 = explicit select, 1 = round-robin.
- `sel`, input, SEL_W: channel index, used only when mode = 0.
- `out_data`, output, WIDTH: registered output word.
- `out_valid`, output, 1: `out_data` holds an unconsumed word.
- `out_ready`, input, 1: consumer accepts the word this cycle.
- `out_chan`, output, SEL_W: index of the channel that supplied `out_data`.

## Operation
- Internal state: output register (`out_data`, `out_chan`, `out_valid`) and round-robin pointer `ptr` (SEL_W bits, range 0..CHANNELS-1).
- `load_en = !out_valid || out_ready`. The output stage can take a new word this cycle.
- Candidate channel:
  - Mode 0: candidate = `sel`. If `sel` >= CHANNELS, there is no candidate.
  - Mode 1: candidate = first i with `in_valid[i]` = 1, scanning ptr, ptr+1, …, CHANNELS-1, 0, …, ptr-1. If no `in_valid` bit is set, there is no candidate.
- Grant: `grant = load_en && candidate exists && in_valid[candidate]`.
- `in_ready[candidate] = grant`. All other `in_ready` bits are 0.
- `in_ready` is combinational from `in_valid`, `mode`, `sel`, `out_valid`, `out_ready` and `ptr`. This valid-to-ready path is permitted.
- On a clock edge with grant:
  - `out_data` <= candidate word.
  - `out_chan` <= candidate.
  - `out_valid` <= 1.
- On a clock edge with no grant and `out_ready` = 1: `out_valid` <= 0. `out_data` and `out_chan` hold their values.
- Otherwise the output register holds. `out_data` and `out_chan` are stable while `out_valid` && !`out_ready`.
- Pointer update:
  - Mode 1 grant to channel k: `ptr` <= (k+1) mod CHANNELS. The channel CHANNELS-1 case wraps to 0.
  - Mode 0, or no grant: `ptr` holds.
- A change of `mode` or `sel` takes effect in the same cycle (combinational). There is no internal mode state beyond `ptr`.
- Reset (asynchronous, immediate):
  - `out_valid` = 0, `out_data` = 0, `out_chan` = 0, `ptr` = 0.
  - All `in_ready` = 0 while `reset` is high, whatever the other inputs are.
  - A word held in the output stage at reset is discarded.

## Timing
- Latency: an input transfer at edge N makes `out_valid` = 1 with that word after edge N, i.e. visible in cycle N+1.
- Throughput: one word per cycle while `out_ready` stays high. Back-to-back grants are allowed because `load_en` is true whenever `out_ready` = 1.
- Simultaneous output consume and new grant in the same cycle: the output is replaced and `out_valid` stays 1, with no bubble.
- Backpressure: with `out_valid` = 1 and `out_ready` = 0, all `in_ready` = 0 and the state is frozen, including `ptr`.
- Input transfer happens only on `in_valid[i]` && `in_ready[i]` at a clock edge. A producer may drop `in_valid` without a transfer.
- Mode 0 with `sel` pointing at an idle channel: no grant and no bubble fill. `out_valid` falls after the current word is consumed.
- Release of `reset` is synchronised externally. The first grant can occur at the first edge after deassertion.

## Test plan
- **Reset mid-stream.** Assert `reset` while `out_valid` = 1 with `out_data` = 0x0005.
  - All outputs go to 0 immediately, without a clock edge.
  - All `in_ready` = 0 while reset is high.
  - `ptr` restarts at 0.
- **Explicit select sweep.** Mode 0, channel i data = i+1 (CHANNELS = 8), all valid, `out_ready` = 1, `sel` stepped 0..7 one per cycle.
  - `out_data` is 1..8 with one-cycle lag.
  - `out_chan` = `sel` of the previous cycle.
  - Only `in_ready[sel]` is high.
- **Round-robin fairness and wrap.** Mode 1, all 8 channels always valid, `out_ready` = 1.
  - `out_chan` sequence is 0,1,…,7,0,1.
  - Exactly one `in_ready` bit is high per cycle.
- **Sparse round-robin.** Mode 1, only channels 2 and 6 valid.
  - Grants alternate 2,6,2,6.
  - Then drop channel 2: grants 6,6,6 with `ptr` = 7→wraps, and the scan finds 6.
- **Backpressure.** `out_ready` = 0 for 3 cycles after a word 0x0003 from channel 2 loads.
  - `out_data` = 0x0003 and `out_chan` = 2 are held.
  - All `in_ready` = 0 and `ptr` is unchanged.
  - Raising `out_ready` consumes the word and loads the next word in the same edge.
- **Invalid select.** Set `sel` = 7 with CHANNELS = 6 (mode 0).
  - No grant and all `in_ready` = 0.
  - `out_valid` clears after the pending word is consumed.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel registered stream mux, explicit select or
// round-robin arbitration into a single valid/ready output stage.
module stream_mux_rr #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan
);

  localparam logic [SEL_W:0]   NCH  = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS-1);
  localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);

  logic [SEL_W-1:0]      ptr;
  logic                  load_en;
  logic [2*CHANNELS-1:0] dbl;
  logic [CHANNELS-1:0]   rot;
  logic                  rr_hit;
  logic [SEL_W-1:0]      rr_off;
  logic [SEL_W:0]        rr_sum;
  logic [SEL_W-1:0]      rr_idx;
  logic                  sel_ok;
  logic                  cand_ok;
  logic [SEL_W-1:0]      cand;
  logic                  cand_vld;
  logic [WIDTH-1:0]      cand_data;
  logic                  grant;

  assign load_en = !out_valid || out_ready;

  // rot[k] is the valid bit of channel (ptr+k) mod CHANNELS
  assign dbl = {in_valid, in_valid} >> ptr;
  assign rot = dbl[CHANNELS-1:0];

  always_comb begin
    rr_hit = 1'b0;
    rr_off = '0;
    for (int k = CHANNELS-1; k >= 0; k--) begin
      if (rot[k]) begin
        rr_hit = 1'b1;
        rr_off = SEL_W'(k);
      end
    end
  end

  assign rr_sum = {1'b0, ptr} + {1'b0, rr_off};
  assign rr_idx = (rr_sum >= NCH) ? SEL_W'(rr_sum - NCH)
                                  : rr_sum[SEL_W-1:0];

  assign sel_ok  = ({1'b0, sel} < NCH);
  assign cand    = mode ? rr_idx : sel;
  assign cand_ok = mode ? rr_hit : sel_ok;

  always_comb begin
    cand_vld  = 1'b0;
    cand_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (cand == SEL_W'(k)) begin
        cand_vld  = in_valid[k];
        cand_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign grant = load_en && cand_ok && cand_vld && !reset;

  always_comb begin
    in_ready = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      in_ready[k] = grant && (cand == SEL_W'(k));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else begin
      if (grant) begin
        out_data  <= cand_data;
        out_chan  <= cand;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (grant && mode) begin
        ptr <= (cand == LAST) ? '0 : cand + ONE;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed plan steps plus random traffic checked
// against a cycle-level behavioural model of the mux.
module tb_stream_mux_rr;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] in_data;
  logic [7:0]   in_valid;
  logic [7:0]   in_ready;
  logic         mode;
  logic [2:0]   sel;
  logic [15:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_chan;

  logic [95:0]  b_in_data;
  logic [5:0]   b_in_valid;
  logic [5:0]   b_in_ready;
  logic         b_mode;
  logic [2:0]   b_sel;
  logic [15:0]  b_out_data;
  logic         b_out_valid;
  logic         b_out_ready;
  logic [2:0]   b_out_chan;

  int tests = 0;
  int fails = 0;

  bit          m_valid;
  logic [15:0] m_data;
  int          m_chan;
  int          m_ptr;

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(16), .CHANNELS(8), .SEL_W(3)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_chan(out_chan)
  );

  stream_mux_rr #(.WIDTH(16), .CHANNELS(6), .SEL_W(3)) dut6 (
    .clk(clk), .reset(reset),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .mode(b_mode), .sel(b_sel),
    .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_chan(b_out_chan)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] word(input int c);
    return in_data[c*16 +: 16];
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = 0;
    m_ptr   = 0;
  endtask

  // one cycle: check combinational and registered state, then advance model
  task automatic step();
    int         cand;
    bit         g;
    logic [7:0] er;
    #1;
    cand = -1;
    if (mode == 1'b0) begin
      if (int'(sel) < 8) cand = int'(sel);
    end else begin
      for (int k = 0; k < 8; k++) begin
        int idx;
        idx = (m_ptr + k) % 8;
        if (cand < 0 && in_valid[idx]) cand = idx;
      end
    end
    g  = (!m_valid || out_ready) && cand >= 0 && in_valid[cand];
    er = g ? 8'(1 << cand) : 8'h00;
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_chan", 32'(out_chan), 32'(m_chan));
    chk("ptr", 32'(dut.ptr), 32'(m_ptr));
    @(posedge clk);
    if (g) begin
      m_data  = word(cand);
      m_chan  = cand;
      m_valid = 1'b1;
      if (mode) m_ptr = (cand + 1) % 8;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    int exp_sp[4];
    reset       = 1'b1;
    in_valid    = '0;
    mode        = 1'b0;
    sel         = '0;
    out_ready   = 1'b0;
    b_in_valid  = '0;
    b_mode      = 1'b0;
    b_sel       = '0;
    b_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) in_data[i*16 +: 16] = 16'(i + 1);
    for (int i = 0; i < 6; i++) b_in_data[i*16 +: 16] = 16'(16 + i);
    model_reset();
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // explicit select sweep
    in_valid  = 8'hff;
    out_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      step();
      chk("sweep_data", 32'(out_data), 32'(s + 1));
      chk("sweep_chan", 32'(out_chan), 32'(s));
    end

    // round-robin fairness and wrap
    mode = 1'b1;
    for (int r = 0; r < 10; r++) begin
      step();
      chk("rr_chan", 32'(out_chan), 32'(r % 8));
    end

    // sparse round-robin
    in_valid = 8'h44;
    exp_sp = '{2, 6, 2, 6};
    for (int r = 0; r < 4; r++) begin
      step();
      chk("sparse_chan", 32'(out_chan), 32'(exp_sp[r]));
    end
    in_valid = 8'h40;
    for (int r = 0; r < 3; r++) begin
      step();
      chk("sparse6_chan", 32'(out_chan), 6);
      chk("sparse6_ptr", 32'(dut.ptr), 7);
    end

    // backpressure
    mode     = 1'b0;
    sel      = 3'd2;
    in_valid = 8'hff;
    step();
    chk("bp_load", 32'(out_data), 3);
    out_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      step();
      chk("bp_hold_data", 32'(out_data), 3);
      chk("bp_hold_chan", 32'(out_chan), 2);
    end
    sel       = 3'd3;
    out_ready = 1'b1;
    step();
    chk("bp_release_data", 32'(out_data), 4);
    chk("bp_release_valid", 32'(out_valid), 1);

    // reset mid-stream
    sel = 3'd4;
    step();
    chk("pre_rst_data", 32'(out_data), 5);
    out_ready = 1'b0;
    mode      = 1'b1;
    step();
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    chk("mid_rst_chan", 32'(out_chan), 0);
    chk("mid_rst_ptr", 32'(dut.ptr), 0);
    chk("mid_rst_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_hold_ready", 32'(in_ready), 0);
    chk("rst_hold_valid", 32'(out_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step();
    chk("post_rst_chan", 32'(out_chan), 0);

    // random traffic against the model
    for (int r = 0; r < 500; r++) begin
      for (int i = 0; i < 8; i++) in_data[i*16 +: 16] = 16'($urandom);
      in_valid  = 8'($urandom);
      mode      = 1'($urandom_range(0, 1));
      sel       = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // invalid select on the 6-channel instance
    b_in_valid  = 6'h3f;
    b_sel       = 3'd1;
    b_out_ready = 1'b1;
    #1;
    chk("b_sel1_ready", 32'(b_in_ready), 32'h02);
    @(posedge clk);
    @(negedge clk);
    chk("b_load_valid", 32'(b_out_valid), 1);
    chk("b_load_data", 32'(b_out_data), 32'h11);
    b_out_ready = 1'b0;
    b_sel       = 3'd7;
    #1;
    chk("b_sel7_ready", 32'(b_in_ready), 0);
    @(posedge clk);
    @(negedge clk);
    chk("b_hold_valid", 32'(b_out_valid), 1);
    b_sel = 3'd6;
    #1;
    chk("b_sel6_ready", 32'(b_in_ready), 0);
    b_sel       = 3'd7;
    b_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("b_drain_valid", 32'(b_out_valid), 0);
    chk("b_drain_data", 32'(b_out_data), 32'h11);
    chk("b_drain_chan", 32'(b_out_chan), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
